// File: rtl/wb_stage.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | wb_stage: RV32I writeback stage; formats load data and drives the regfile |
// | write port. Optional macro WB_INSTRET_EN adds a 64-bit retire counter.    |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module wb_stage #(
  parameter int XLEN        = 32,
  parameter int RFIDX_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   m_valid,
  output logic                   m_ready,
  input  logic [RFIDX_WIDTH-1:0] m_rd_index,
  input  logic [XLEN-1:0]        m_alu_result,
  input  logic [2:0]             m_mem_mode,
  input  logic                   m_mem_read,
  input  logic                   m_wb_reg_write,
  input  logic                   m_wb_memtoreg,
  input  logic                   dmem_rsp_valid,
  input  logic [31:0]            dmem_rsp_data,
  output logic                   reg_write,
  output logic [RFIDX_WIDTH-1:0] write_index,
  output logic [XLEN-1:0]        write_data,
  output logic                   wb_busy
`ifdef WB_INSTRET_EN
  ,
  output logic [63:0]            instret
`endif
);

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_RSP = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic                   reg_write_q, reg_write_d;
  logic [RFIDX_WIDTH-1:0] write_index_q, write_index_d;
  logic [XLEN-1:0]        write_data_q, write_data_d;
  logic [RFIDX_WIDTH-1:0] ld_rd_q, ld_rd_d;
  logic [2:0]             ld_mode_q, ld_mode_d;
  logic [1:0]             ld_addr_q, ld_addr_d;
  logic                   ld_we_q, ld_we_d;
  logic                   w_retire;
  logic [7:0]             w_byte;
  logic [15:0]            w_half;
  logic [31:0]            w_load32;
  logic [XLEN-1:0]        w_load_data;

  // Byte/halfword lane selection from the latched address offset.
  always_comb begin
    w_byte = dmem_rsp_data[7:0];
    case (ld_addr_q)
      2'd1:    w_byte = dmem_rsp_data[15:8];
      2'd2:    w_byte = dmem_rsp_data[23:16];
      2'd3:    w_byte = dmem_rsp_data[31:24];
      default: w_byte = dmem_rsp_data[7:0];
    endcase
    w_half = ld_addr_q[1] ? dmem_rsp_data[31:16] : dmem_rsp_data[15:0];
    case (ld_mode_q)
      3'b000:  w_load32 = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load32 = {{16{w_half[15]}}, w_half};
      3'b100:  w_load32 = {24'd0, w_byte};
      3'b101:  w_load32 = {16'd0, w_half};
      default: w_load32 = dmem_rsp_data;
    endcase
    w_load_data = XLEN'($signed(w_load32));
  end

  always_comb begin
    state_d       = state_q;
    reg_write_d   = 1'b0;
    write_index_d = write_index_q;
    write_data_d  = write_data_q;
    ld_rd_d       = ld_rd_q;
    ld_mode_d     = ld_mode_q;
    ld_addr_d     = ld_addr_q;
    ld_we_d       = ld_we_q;
    w_retire      = 1'b0;
    case (state_q)
      IDLE: begin
        if (m_valid) begin
          if (m_wb_memtoreg && m_mem_read) begin
            ld_rd_d   = m_rd_index;
            ld_mode_d = m_mem_mode;
            ld_addr_d = m_alu_result[1:0];
            ld_we_d   = m_wb_reg_write;
            state_d   = WAIT_RSP;
          end else begin
            reg_write_d   = m_wb_reg_write && (m_rd_index != '0);
            write_index_d = m_rd_index;
            write_data_d  = m_alu_result;
            w_retire      = 1'b1;
          end
        end
      end
      WAIT_RSP: begin
        if (dmem_rsp_valid) begin
          reg_write_d   = ld_we_q && (ld_rd_q != '0);
          write_index_d = ld_rd_q;
          write_data_d  = w_load_data;
          w_retire      = 1'b1;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      reg_write_q   <= 1'b0;
      write_index_q <= '0;
      write_data_q  <= '0;
      ld_rd_q       <= '0;
      ld_mode_q     <= 3'b010;
      ld_addr_q     <= 2'b00;
      ld_we_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      reg_write_q   <= reg_write_d;
      write_index_q <= write_index_d;
      write_data_q  <= write_data_d;
      ld_rd_q       <= ld_rd_d;
      ld_mode_q     <= ld_mode_d;
      ld_addr_q     <= ld_addr_d;
      ld_we_q       <= ld_we_d;
    end
  end

`ifdef WB_INSTRET_EN
  logic [63:0] instret_q;

  // Counts every completed instruction, including rd==x0 and non-writing ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instret_q <= 64'd0;
    end else if (w_retire) begin
      instret_q <= instret_q + 64'd1;
    end
  end

  assign instret = instret_q;
`else
  logic w_unused_retire;
  assign w_unused_retire = w_retire;
`endif

  assign m_ready     = (state_q == IDLE);
  assign wb_busy     = (state_q == WAIT_RSP);
  assign reg_write   = reg_write_q;
  assign write_index = write_index_q;
  assign write_data  = write_data_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
// Self-checking bench for wb_stage: directed vector table, reset-mid-load
// sequence, and randomized traffic against a behavioural reference model.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m_valid = 1'b0;
  logic        m_ready;
  logic [4:0]  m_rd_index = '0;
  logic [31:0] m_alu_result = '0;
  logic [2:0]  m_mem_mode = '0;
  logic        m_mem_read = 1'b0;
  logic        m_wb_reg_write = 1'b0;
  logic        m_wb_memtoreg = 1'b0;
  logic        dmem_rsp_valid = 1'b0;
  logic [31:0] dmem_rsp_data = '0;
  logic        reg_write;
  logic [4:0]  write_index;
  logic [31:0] write_data;
  logic        wb_busy;
`ifdef WB_INSTRET_EN
  logic [63:0] instret;
`endif

  int n_pass  = 0;
  int n_total = 0;

  wb_stage #(.XLEN(32), .RFIDX_WIDTH(5)) dut (
    .clk            (clk),
    .rst            (rst),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .m_rd_index     (m_rd_index),
    .m_alu_result   (m_alu_result),
    .m_mem_mode     (m_mem_mode),
    .m_mem_read     (m_mem_read),
    .m_wb_reg_write (m_wb_reg_write),
    .m_wb_memtoreg  (m_wb_memtoreg),
    .dmem_rsp_valid (dmem_rsp_valid),
    .dmem_rsp_data  (dmem_rsp_data),
    .reg_write      (reg_write),
    .write_index    (write_index),
    .write_data     (write_data),
    .wb_busy        (wb_busy)
`ifdef WB_INSTRET_EN
    ,
    .instret        (instret)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [2:0]  mode;
    logic        mread;
    logic        we;
    logic        m2r;
    logic        rv;
    logic [31:0] rdata;
    logic        e_ready;
    logic        e_busy;
    logic        e_rw;
    logic [4:0]  e_idx;
    logic [31:0] e_data;
  } vec_t;

  vec_t vecs[19];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] rd, input logic [31:0] alu,
                       input logic [2:0] mode, input logic mread, input logic we,
                       input logic m2r, input logic rv, input logic [31:0] rdata);
    m_valid = v; m_rd_index = rd; m_alu_result = alu; m_mem_mode = mode;
    m_mem_read = mread; m_wb_reg_write = we; m_wb_memtoreg = m2r;
    dmem_rsp_valid = rv; dmem_rsp_data = rdata;
  endtask

  task automatic idle_inputs();
    drive(1'b0, 5'd0, 32'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
  endtask

  // Load result computed from the RISC-V load rules with plain arithmetic.
  function automatic logic [31:0] ref_load(input logic [2:0] mode, input logic [1:0] a,
                                           input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * a)) & 32'hFF;
    h = (w >> (16 * a[1])) & 32'hFFFF;
    case (mode)
      3'b000:  return (b >= 32'd128)   ? b + 32'hFFFF_FF00 : b;
      3'b001:  return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return w;
    endcase
  endfunction

  // Reference model state.
  bit          mdl_pend;
  logic [4:0]  mdl_prd;
  logic [2:0]  mdl_pmode;
  logic [1:0]  mdl_pa;
  logic        mdl_pwe;
  logic        mdl_rw;
  logic [4:0]  mdl_idx;
  logic [31:0] mdl_data;
  longint unsigned mdl_ret;

  task automatic model_reset();
    mdl_pend = 0; mdl_rw = 0; mdl_idx = 0; mdl_data = 0; mdl_ret = 0;
    mdl_prd = 0; mdl_pmode = 0; mdl_pa = 0; mdl_pwe = 0;
  endtask

  task automatic model_step();
    mdl_rw = 1'b0;
    if (mdl_pend) begin
      if (dmem_rsp_valid) begin
        mdl_rw   = mdl_pwe && (mdl_prd != 0);
        mdl_idx  = mdl_prd;
        mdl_data = ref_load(mdl_pmode, mdl_pa, dmem_rsp_data);
        mdl_pend = 0;
        mdl_ret++;
      end
    end else if (m_valid) begin
      if (m_wb_memtoreg && m_mem_read) begin
        mdl_pend = 1; mdl_prd = m_rd_index; mdl_pmode = m_mem_mode;
        mdl_pa = m_alu_result[1:0]; mdl_pwe = m_wb_reg_write;
      end else begin
        mdl_rw   = m_wb_reg_write && (m_rd_index != 0);
        mdl_idx  = m_rd_index;
        mdl_data = m_alu_result;
        mdl_ret++;
      end
    end
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    //            v     rd     alu            mode    mr    we    m2r   rv    rdata           rdy   bsy   rw    idx    data
    vecs[0]  = '{1'b1, 5'd5, 32'h1234_5678, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,          1'b1, 1'b0, 1'b0, 5'd0, 32'h0};
    vecs[1]  = '{1'b0, 5'd0, 32'h0,         3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,          1'b1, 1'b0, 1'b1, 5'd5, 32'h1234_5678};
    vecs[2]  = '{1'b1, 5'd3, 32'h0000_1002, 3'b000, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,          1'b1, 1'b0, 1'b0, 5'd5, 32'h1234_5678};
    vecs[3]  = '{1'b0, 5'd0, 32'h0,         3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,          1'b0, 1'b1, 1'b0, 5'd5, 32'h1234_5678};
    vecs[4]  = '{1'b0, 5'd0, 32'h0,         3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,          1'b0, 1'b1, 1'b0, 5'd5, 32'h1234_5678};
    vecs[5]  = '{1'b0, 5'd0, 32'h0,         3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0080_0000, 1'b0, 1'b1, 1'b0, 5'd5, 32'h1234_5678};
    vecs[6]  = '{1'b1, 5'd7, 32'h0000_0002, 3'b101, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,          1'b1, 1'b0, 1'b1, 5'd3, 32'hFFFF_FF80};
    vecs[7]  = '{1'b0, 5'd0, 32'h0,         3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 32'hBEEF_0000, 1'b0, 1'b1, 1'b0, 5'd3, 32'hFFFF_FF80};
    vecs[8]  = '{1'b1, 5'd8, 32'h0000_0000, 3'b010, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,          1'b1, 1'b0, 1'b1, 5'd7, 32'h0000_BEEF};
    vecs[9]  = '{1'b0, 5'd0, 32'h0,         3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 32'hCAFE_BABE, 1'b0, 1'b1, 1'b0, 5'd7, 32'h0000_BEEF};
    vecs[10] = '{1'b1, 5'd1, 32'h11,        3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,          1'b1, 1'b0, 1'b1, 5'd8, 32'hCAFE_BABE};
    vecs[11] = '{1'b1, 5'd0, 32'h22,        3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,          1'b1, 1'b0, 1'b1, 5'd1, 32'h11};
    vecs[12] = '{1'b1, 5'd2, 32'h33,        3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,          1'b1, 1'b0, 1'b0, 5'd0, 32'h22};
    vecs[13] = '{1'b1, 5'd3, 32'h44,        3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,          1'b1, 1'b0, 1'b1, 5'd2, 32'h33};
    vecs[14] = '{1'b0, 5'd0, 32'h0,         3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,          1'b1, 1'b0, 1'b1, 5'd3, 32'h44};
    vecs[15] = '{1'b0, 5'd0, 32'h0,         3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0,          1'b1, 1'b0, 1'b0, 5'd3, 32'h44};
    vecs[16] = '{1'b1, 5'd9, 32'h55,        3'b000, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,          1'b1, 1'b0, 1'b0, 5'd3, 32'h44};
    vecs[17] = '{1'b0, 5'd0, 32'h0,         3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,          1'b1, 1'b0, 1'b1, 5'd9, 32'h55};
    vecs[18] = '{1'b0, 5'd0, 32'h0,         3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,          1'b1, 1'b0, 1'b0, 5'd9, 32'h55};

    // Reset state, sampled while reset is still asserted.
    idle_inputs();
    tick();
    check("reset_outputs", {25'd0, m_ready, wb_busy, reg_write, write_index, write_data},
          {25'd0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0});
    rst = 1'b0;
    tick();

    // Directed vector table: outputs reflect the previous row's clock edge.
    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].valid, vecs[i].rd, vecs[i].alu, vecs[i].mode, vecs[i].mread,
            vecs[i].we, vecs[i].m2r, vecs[i].rv, vecs[i].rdata);
      #1;
      check($sformatf("vec%0d", i),
            {25'd0, m_ready, wb_busy, reg_write, write_index, write_data},
            {25'd0, vecs[i].e_ready, vecs[i].e_busy, vecs[i].e_rw, vecs[i].e_idx, vecs[i].e_data});
      tick();
    end

    // Reset in the middle of a load; a later response must be dropped.
    do_reset();
    drive(1'b1, 5'd4, 32'h0000_0001, 3'b000, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    tick();
    idle_inputs();
    #3;
    check("busy_before_rst", {62'd0, m_ready, wb_busy}, {62'd0, 1'b0, 1'b1});
    rst = 1'b1;
    #1;
    check("async_rst_idle", {62'd0, m_ready, wb_busy}, {62'd0, 1'b1, 1'b0});
    tick();
    rst = 1'b0;
    dmem_rsp_valid = 1'b1;
    dmem_rsp_data  = 32'hFFFF_FFFF;
    tick();
    dmem_rsp_valid = 1'b0;
    check("rsp_after_rst", {25'd0, m_ready, wb_busy, reg_write, write_index, write_data},
          {25'd0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0});
    tick();
    check("rsp_after_rst_2", {62'd0, reg_write, m_ready}, {62'd0, 1'b0, 1'b1});

`ifdef WB_INSTRET_EN
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'(i + 1), 32'(i), 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      tick();
    end
    drive(1'b1, 5'd0, 32'h0, 3'b010, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    tick();
    idle_inputs();
    dmem_rsp_valid = 1'b1;
    tick();
    idle_inputs();
    check("instret_four", instret, 64'd4);
    force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.instret_q;
    drive(1'b1, 5'd1, 32'h0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    idle_inputs();
    check("instret_wrap", instret, 64'd0);
`endif

    // Randomized traffic against the reference model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      check("rand_ready_busy", {62'd0, m_ready, wb_busy}, {62'd0, !mdl_pend, mdl_pend});
      check("rand_wport", {25'd0, reg_write, write_index, write_data},
            {25'd0, 1'b0, 1'b0, mdl_rw, mdl_idx, mdl_data});
`ifdef WB_INSTRET_EN
      check("rand_instret", instret, mdl_ret);
`endif
      m_valid        = ($urandom_range(0, 3) != 0);
      m_rd_index     = 5'($urandom_range(0, 31));
      m_alu_result   = $urandom;
      m_mem_mode     = 3'($urandom_range(0, 7));
      m_mem_read     = $urandom_range(0, 1) == 1;
      m_wb_memtoreg  = $urandom_range(0, 1) == 1;
      m_wb_reg_write = ($urandom_range(0, 4) != 0);
      dmem_rsp_valid = ($urandom_range(0, 2) == 0);
      dmem_rsp_data  = $urandom;
      model_step();
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
